// File: rtl/deck_pkg.sv
// Shared constants, types and LFSR step for the deck dealer.
// Galois LFSR step for x^16+x^14+x^13+x^11+1.
package deck_pkg;

  localparam int DECK_SIZE = 52;
  localparam int CARD_W    = 7;
  localparam int ADDR_W    = 6;
  localparam int LFSR_W    = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;

  typedef logic [CARD_W-1:0] card_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_PICK   = 4'd2;
  localparam logic [3:0] S_RD_I   = 4'd3;
  localparam logic [3:0] S_RD_J   = 4'd4;
  localparam logic [3:0] S_CAP_J  = 4'd5;
  localparam logic [3:0] S_WR_I   = 4'd6;
  localparam logic [3:0] S_WR_J   = 4'd7;
  localparam logic [3:0] S_READY  = 4'd8;
  localparam logic [3:0] S_DEAL_A = 4'd9;
  localparam logic [3:0] S_DEAL_B = 4'd10;

  typedef enum logic [3:0] {
    IDLE   = S_IDLE,
    INIT   = S_INIT,
    PICK   = S_PICK,
    RD_I   = S_RD_I,
    RD_J   = S_RD_J,
    CAP_J  = S_CAP_J,
    WR_I   = S_WR_I,
    WR_J   = S_WR_J,
    READY  = S_READY,
    DEAL_A = S_DEAL_A,
    DEAL_B = S_DEAL_B
  } dealer_state_t;

  // Right-shifting Galois form: the bit shifted out
  // folds back through the tap mask.
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] v
  );
    logic [LFSR_W-1:0] r;
    r = {1'b0, v[LFSR_W-1:1]};
    if (v[0]) r = r ^ LFSR_TAPS;
    return r;
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// Shuffle LFSR: loads a seed (0 maps to the default), steps on advance.
// Ports: clk, rst (sync high), load, seed, advance, value.
module deck_lfsr
  import deck_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_SEED_DEFAULT;
    end else if (load) begin
      // All-zero is the LFSR lock-up state.
      value <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/deck_dealer.sv
// Deck dealer: fills deck memory 0..51, Fisher-Yates shuffles it in place
// with an LFSR, then deals one card per deal_req (card_valid pulse).
// Ports: clk, rst, start_shuffle, seed, deal_req, busy, ready, card_valid,
// card_out, deck_empty, cards_left, mem_addr/mem_wen/mem_wdata, mem_rdata.
// Optional macro DEALER_DUP_CHECK_EN adds dup_error (repeat/invalid card).
module deck_dealer
  import deck_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_shuffle,
  input  logic [LFSR_W-1:0] seed,
  input  logic              deal_req,
  output logic              busy,
  output logic              ready,
  output logic              card_valid,
  output logic [CARD_W-1:0] card_out,
  output logic              deck_empty,
  output logic [ADDR_W-1:0] cards_left,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [CARD_W-1:0] mem_wdata,
  input  logic [CARD_W-1:0] mem_rdata
`ifdef DEALER_DUP_CHECK_EN
  ,
  output logic              dup_error
`endif
);

  localparam addr_t LAST = addr_t'(DECK_SIZE - 1);
  localparam addr_t FULL = addr_t'(DECK_SIZE);

  dealer_state_t state;

  addr_t idx;
  addr_t i_q;
  addr_t j_q;
  card_t a_q;
  card_t b_q;
  addr_t ptr;
  addr_t left_q;

  logic [LFSR_W-1:0] lfsr_q;
  addr_t             lfsr_j;
  logic              start_ok;
  logic              unused_lfsr_hi;

  assign start_ok = start_shuffle &&
                    (state == IDLE || state == READY);

  assign lfsr_j         = lfsr_q[ADDR_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:ADDR_W];

  deck_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .seed    (seed),
    .advance (state == PICK),
    .value   (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ptr        <= '0;
      left_q     <= '0;
      card_out   <= '0;
      card_valid <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            idx    <= '0;
            ptr    <= '0;
            left_q <= '0;
            state  <= INIT;
          end
        end
        INIT: begin
          if (idx == LAST) begin
            i_q   <= LAST;
            state <= PICK;
          end else begin
            idx <= idx + addr_t'(1);
          end
        end
        // Rejection sampling keeps j uniform over 0..i.
        PICK: begin
          if (lfsr_j <= i_q) begin
            j_q   <= lfsr_j;
            state <= RD_I;
          end
        end
        RD_I: state <= RD_J;
        RD_J: begin
          a_q   <= mem_rdata;
          state <= CAP_J;
        end
        CAP_J: begin
          b_q   <= mem_rdata;
          state <= WR_I;
        end
        WR_I: state <= WR_J;
        WR_J: begin
          if (i_q == addr_t'(1)) begin
            ptr    <= '0;
            left_q <= FULL;
            state  <= READY;
          end else begin
            i_q   <= i_q - addr_t'(1);
            state <= PICK;
          end
        end
        READY: begin
          if (start_ok) begin
            idx    <= '0;
            ptr    <= '0;
            left_q <= '0;
            state  <= INIT;
          end else if (deal_req && left_q != '0) begin
            state <= DEAL_A;
          end
        end
        DEAL_A: state <= DEAL_B;
        DEAL_B: begin
          card_out   <= mem_rdata;
          card_valid <= 1'b1;
          ptr        <= ptr + addr_t'(1);
          left_q     <= left_q - addr_t'(1);
          state      <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    unique case (state)
      INIT: begin
        mem_addr  = idx;
        mem_wen   = 1'b1;
        mem_wdata = card_t'(idx);
      end
      RD_I: mem_addr = i_q;
      RD_J: mem_addr = j_q;
      WR_I: begin
        mem_addr  = i_q;
        mem_wen   = 1'b1;
        mem_wdata = b_q;
      end
      WR_J: begin
        mem_addr  = j_q;
        mem_wen   = 1'b1;
        mem_wdata = a_q;
      end
      // Hold the address through DEAL_B so the
      // registered read stays stable for capture.
      DEAL_A: mem_addr = ptr;
      DEAL_B: mem_addr = ptr;
      default: ;
    endcase
  end

  assign busy       = (state != IDLE) && (state != READY);
  assign ready      = (state == READY);
  assign deck_empty = (left_q == '0);
  assign cards_left = left_q;

`ifdef DEALER_DUP_CHECK_EN
  logic [DECK_SIZE-1:0] dealt_mask;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      dealt_mask <= '0;
      dup_error  <= 1'b0;
    end else if (card_valid) begin
      if (card_out >= card_t'(DECK_SIZE)) begin
        dup_error <= 1'b1;
      end else if (dealt_mask[card_out[ADDR_W-1:0]]) begin
        dup_error <= 1'b1;
      end else begin
        dealt_mask[card_out[ADDR_W-1:0]] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_deck_dealer.sv
// Bench for deck_dealer: deck memory model, shuffle/deal reference model,
// randomized stimulus and a per-cycle compare process.
`timescale 1ns/1ps
module tb_deck_dealer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_shuffle;
  logic [15:0] seed;
  logic        deal_req;
  logic        busy, ready, card_valid, deck_empty, mem_wen;
  logic [6:0]  card_out, mem_wdata, mem_rdata;
  logic [5:0]  cards_left, mem_addr;
`ifdef DEALER_DUP_CHECK_EN
  logic        dup_error;
`endif

  always #5 clk = ~clk;

  deck_dealer dut (
    .clk           (clk),
    .rst           (rst),
    .start_shuffle (start_shuffle),
    .seed          (seed),
    .deal_req      (deal_req),
    .busy          (busy),
    .ready         (ready),
    .card_valid    (card_valid),
    .card_out      (card_out),
    .deck_empty    (deck_empty),
    .cards_left    (cards_left),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
`ifdef DEALER_DUP_CHECK_EN
    ,
    .dup_error     (dup_error)
`endif
  );

  // Deck memory: registered read, write on wen.
  logic [6:0] mem [0:63];
  logic [6:0] rd_q;
  bit         force_dup = 1'b0;
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[mem_addr];
  end
  assign mem_rdata = force_dup ? 7'd7 : rd_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int NEVER = 32'h7fffffff;
  int ready_from      = NEVER;
  int prev_ready_from = NEVER;
  int busy_start      = 0;
  int active_from     = NEVER;
  int issued          = 0;
  int order_m [52];
  int ord_1234 [52];
  int ord_ace1 [52];

  typedef struct {
    int at;
    int card;
    int left;
  } exp_t;
  exp_t expq[$];
  int   seen[$];

  function automatic logic [15:0] step16(input logic [15:0] x);
    logic [15:0] r;
    r = x >> 1;
    if (x[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Fisher-Yates on a plain array; returns the busy cycle count
  // (52 fills, then per position: draws + 2 reads, capture, 2 writes).
  function automatic int model_shuffle(input logic [15:0] s);
    logic [15:0] l;
    int j, t, n, tmp;
    l = (s == 16'h0) ? 16'hACE1 : s;
    for (int k = 0; k < 52; k++) order_m[k] = k;
    n = 52;
    for (int i = 51; i >= 1; i--) begin
      t = 0;
      do begin
        j = int'(l[5:0]);
        l = step16(l);
        t++;
      end while (j > i);
      tmp = order_m[i];
      order_m[i] = order_m[j];
      order_m[j] = tmp;
      n += t + 5;
    end
    return n;
  endfunction

  function automatic bit ready_exp(input int x);
    return (x >= prev_ready_from && x < busy_start) || x >= ready_from;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    bit r;
    bit exp_now;
    if (!rst) begin
      r = ready_exp(cyc);
      chk("ready", ready, r);
      chk("busy", busy, (cyc >= active_from) && !r);
      if (cyc < active_from) begin
        chk("idle_empty", deck_empty, 1);
        chk("idle_left", cards_left, 0);
      end
      if (mem_wen) chk("wr_addr_range", mem_addr < 52, 1);
      exp_now = expq.size() > 0 && expq[0].at == cyc;
      chk("card_valid", card_valid, exp_now);
      if (exp_now) begin
        if (card_valid) begin
          chk("card_out", card_out, expq[0].card);
          chk("left_after_deal", cards_left, expq[0].left);
          chk("empty_after_deal", deck_empty, expq[0].left == 0);
          seen.push_back(int'(card_out));
        end
        void'(expq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1 of cycle c; inputs are sampled at edge c+1.
  task automatic step_cyc(input bit st, input bit dr, input logic [15:0] sd);
    int  c;
    int  b;
    bit  rdy;
    c   = cyc;
    rdy = ready_exp(c);
    start_shuffle = st;
    deal_req      = dr;
    seed          = sd;
    if (st && (c < active_from || rdy)) begin
      b = model_shuffle(sd);
      if (c < active_from) active_from = c + 1;
      prev_ready_from = ready_from;
      busy_start      = c + 1;
      ready_from      = c + 1 + b;
      issued          = 0;
    end else if (dr && rdy && issued < 52) begin
      expq.push_back('{c + 3, force_dup ? 7 : order_m[issued], 51 - issued});
      issued++;
      prev_ready_from = ready_from;
      busy_start      = c + 1;
      ready_from      = c + 3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst           = 1'b1;
    start_shuffle = 1'b0;
    deal_req      = 1'b0;
    expq.delete();
    ready_from      = NEVER;
    prev_ready_from = NEVER;
    busy_start      = 0;
    active_from     = NEVER;
    issued          = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic check_mem();
    int          n;
    logic [51:0] m;
    n = 0;
    m = '0;
    for (int k = 0; k < 52; k++) begin
      if (int'(mem[k]) != order_m[k]) n++;
      if (mem[k] < 52) m[mem[k]] = 1'b1;
    end
    chk("mem_vs_model", n, 0);
    chk("mem_perm", int'(&m), 1);
  endtask

  task automatic shuffle(input logic [15:0] sd, input bit noise);
    step_cyc(1'b1, 1'b0, sd);
    chk("busy_on_start", busy, 1);
    for (int k = 0; k < 6000 && !ready_exp(cyc); k++)
      step_cyc(1'b0, noise && ($urandom_range(0, 1) == 1), 16'($urandom));
    chk("ready_after_shuffle", ready, 1);
    chk("left_full", cards_left, 52);
    chk("not_empty", deck_empty, 0);
    check_mem();
  endtask

  task automatic deal_all(input bit gaps);
    logic [51:0] m;
    seen.delete();
    for (int k = 0; k < 3000 && issued < 52; k++)
      step_cyc(1'b0, gaps ? ($urandom_range(0, 2) != 0) : 1'b1, 16'h0);
    repeat (4) step_cyc(1'b0, 1'b0, 16'h0);
    chk("dealt_count", seen.size(), 52);
    m = '0;
    foreach (seen[k]) if (seen[k] < 52) m[seen[k]] = 1'b1;
    chk("deal_perm", int'(&m), 1);
    chk("left_zero", cards_left, 0);
    chk("empty_end", deck_empty, 1);
    // one more request on an empty deck
    step_cyc(1'b0, 1'b1, 16'h0);
    repeat (4) step_cyc(1'b0, 1'b0, 16'h0);
    chk("no_53rd", seen.size(), 52);
  endtask

  function automatic int diff_cnt(input int ref_o [52]);
    int n;
    n = 0;
    if (seen.size() != 52) return 99;
    for (int k = 0; k < 52; k++) if (seen[k] != ref_o[k]) n++;
    return n;
  endfunction

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    do_reset(2);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", deck_empty, 1);
    chk("rst_left", cards_left, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_valid", card_valid, 0);

    // hand-computed pins on the model
    chk("pin_step1", int'(step16(16'hACE1)), 32'hE270);
    chk("pin_step2", int'(step16(16'hE270)), 32'h7138);
    void'(model_shuffle(16'hACE1));
    ord_ace1 = order_m;
    chk("pin_ace1_51", ord_ace1[51], 33);
    chk("pin_ace1_50", ord_ace1[50], 48);
    void'(model_shuffle(16'h1234));
    ord_1234 = order_m;
    chk("pin_1234_51", ord_1234[51], 26);

    // deal_req while idle is ignored
    repeat (3) step_cyc(1'b0, 1'b1, 16'h0);

    // shuffle with deal_req noise, then deal everything
    shuffle(16'h1234, 1'b1);
    deal_all(1'b0);
    chk("seq_1234_a", diff_cnt(ord_1234), 0);

    shuffle(16'h1234, 1'b0);
    deal_all(1'b1);
    chk("seq_1234_b", diff_cnt(ord_1234), 0);

    shuffle(16'h0000, 1'b0);
    deal_all(1'b0);
    chk("seq_seed0_eq_ace1", diff_cnt(ord_ace1), 0);
    chk("last_card_seed0", seen[51], 33);

    shuffle(16'hBEEF, 1'b1);
    deal_all(1'b1);
    chk("beef_differs", diff_cnt(ord_1234) == 0, 0);

    // start_shuffle + deal_req together in READY
    shuffle(16'($urandom), 1'b0);
    step_cyc(1'b1, 1'b1, 16'h5A5A);
    chk("conflict_busy", busy, 1);
    for (int k = 0; k < 6000 && !ready_exp(cyc); k++)
      step_cyc(1'b0, 1'b1, 16'h0);
    chk("conflict_ready", ready, 1);
    check_mem();
    repeat (12) step_cyc(1'b0, 1'b1, 16'h0);

`ifdef DEALER_DUP_CHECK_EN
    shuffle(16'h4321, 1'b0);
    chk("dup_clear", dup_error, 0);
    force_dup = 1'b1;
    repeat (2) begin
      step_cyc(1'b0, 1'b1, 16'h0);
      repeat (3) step_cyc(1'b0, 1'b0, 16'h0);
    end
    force_dup = 1'b0;
    step_cyc(1'b0, 1'b0, 16'h0);
    chk("dup_set", dup_error, 1);
    repeat (5) step_cyc(1'b0, 1'b0, 16'h0);
    chk("dup_held", dup_error, 1);
    step_cyc(1'b1, 1'b0, 16'h4321);
    chk("dup_cleared", dup_error, 0);
    for (int k = 0; k < 6000 && !ready_exp(cyc); k++)
      step_cyc(1'b0, 1'b0, 16'h0);
    deal_all(1'b0);
    chk("dup_none_normal", dup_error, 0);
`endif

    // reset in the middle of a shuffle
    step_cyc(1'b1, 1'b0, 16'h1357);
    repeat (100) step_cyc(1'b0, 1'b0, 16'h0);
    chk("mid_busy", busy, 1);
    do_reset(1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_empty", deck_empty, 1);
    chk("mid_rst_left", cards_left, 0);
    chk("mid_rst_wen", mem_wen, 0);
    repeat (3) step_cyc(1'b0, 1'b1, 16'h0);

    // random traffic: occasional reshuffles, random requests
    step_cyc(1'b1, 1'b0, 16'($urandom));
    for (int k = 0; k < 3000; k++)
      step_cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
               16'($urandom));
    repeat (6) step_cyc(1'b0, 1'b0, 16'h0);
    chk("pending_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
